conv3x3_engine: RTL and testbench
=================================

Name: conv3x3_engine

Overview:
- Downstream compute stage and read sequencer for memory_6.
- Issues the rd strobe that walks the padded image buffer and consumes the nine 3x3 window pixels returned each cycle.
- Applies a selectable 3x3 kernel in a 3-stage pipeline.
- Drives each result into the write port (wr, pixelw) of the same memory block and flags end of frame.

Parameters:
- IMG_W, 256, output pixels per row (one rd cycle per output pixel).
- IMG_H, 32, output rows per frame.
- CNT_W, 15, width of the read and write counters; must hold IMG_W*IMG_H.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a frame when idle.
- mode  input  2  kernel select: 0 = Gaussian, 1 = Sobel magnitude, 2/3 = identity (centre pixel); sampled at start.
- pixelr1..pixelr9  input  8 each  window pixels, row-major: 1-3 top, 4-6 middle, 7-9 bottom; valid one cycle after rd.
- rd  output  1  read strobe to the memory.
- wr  output  1  write strobe to the memory; high for exactly one cycle per result.
- pixelw  output  8  filtered result, valid when wr = 1.
- busy  output  1  high from the cycle after an accepted start until frame_done.
- frame_done  output  1  one-cycle pulse on the cycle after the last wr.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - rd, wr, busy, frame_done = 0; pixelw = 0.
  - All counters and pipeline valid bits cleared; FSM forced to IDLE.
  - Reset during a frame aborts the frame immediately; no frame_done is produced.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: on start = 1, latch mode into mode_q, clear rd_cnt and wr_cnt, go to READ. start while not IDLE is ignored.
  - READ: rd = 1 every cycle; rd_cnt increments. When rd_cnt = IMG_W*IMG_H-1, go to DRAIN (that cycle is the last rd).
  - DRAIN: rd = 0. Go to DONE when the last result has been written, i.e. wr = 1 with wr_cnt = IMG_W*IMG_H-1.
  - DONE: frame_done = 1 for one cycle, busy drops, go to IDLE.
- Input valid: v0 = rd delayed one cycle, matching the memory's registered read. Inputs are ignored when v0 = 0; the memory drives zeros when rd is low, and these must not generate wr.
- Pipeline: v0 -> S1 -> S2 -> S3. wr = S3 valid, so wr follows rd by exactly 4 cycles (1 memory + 3 engine). No stalls.
  - S1: form partial sums per mode_q.
  - S2: combine the sums; take absolute values for Sobel.
  - S3: normalise or saturate to 8 bits; register pixelw.
- Arithmetic, all unsigned pixels:
  - Gaussian: s = (p1+p3+p7+p9) + 2*(p2+p4+p6+p8) + 4*p5. 12-bit, max 4080. pixelw = s >> 4 (truncate).
  - Sobel: Gx = (p3+2*p6+p9) - (p1+2*p4+p7); Gy = (p7+2*p8+p9) - (p1+2*p2+p3). Both 11-bit signed. m = |Gx| + |Gy|, max 2040. pixelw = 255 if m > 255, else m.
  - Identity: pixelw = p5.
- Counters:
  - wr_cnt increments on each wr.
  - Exactly IMG_W*IMG_H rd cycles and IMG_W*IMG_H wr pulses per frame, contiguous, with no gaps.
- mode changes during a frame have no effect; mode_q holds until the next accepted start.
- pixelw holds its last value while wr = 0.

Test Plan:
- Gaussian, all window pixels 100 -> every pixelw = 100 (1600 >> 4). All window pixels 255 -> 255.
- Sobel, p1 = p4 = p7 = 0, p3 = p6 = p9 = 200, rest 0 -> Gx = 800 -> pixelw = 255. Sobel, p3 = 10, all others 0 -> Gx = 10, Gy = -10 -> pixelw = 20.
- Identity, p5 = 0x5A, others random -> pixelw = 0x5A. Check that the first wr occurs exactly 4 cycles after the first rd.
- Full frame, IMG_W = 256, IMG_H = 32 -> exactly 8192 contiguous rd cycles and 8192 wr pulses. frame_done pulses one cycle after the final wr; busy then low.
- Second start pulse and a mode toggle mid-frame -> no restart, rd/wr counts unchanged, results still use the mode latched at start.
- rst_n low for one cycle mid-READ -> rd, wr, busy drop asynchronously with no frame_done. A subsequent start runs a complete 8192-pixel frame.

Source files
------------

// File: rtl/conv3x3_engine.sv
// 3x3 convolution engine: sequences reads from the padded image buffer, filters
// each window (Gaussian / Sobel magnitude / identity) and writes the result back.
//
// state | meaning
// IDLE  | waiting for start
// READ  | one rd per cycle until the whole frame has been requested
// DRAIN | rd off, pipeline still delivering results
// DONE  | one-cycle frame_done, then back to IDLE
module conv3x3_engine #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 32,
    parameter int CNT_W = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic [7:0] pixelr1,
    input  logic [7:0] pixelr2,
    input  logic [7:0] pixelr3,
    input  logic [7:0] pixelr4,
    input  logic [7:0] pixelr5,
    input  logic [7:0] pixelr6,
    input  logic [7:0] pixelr7,
    input  logic [7:0] pixelr8,
    input  logic [7:0] pixelr9,
    output logic       rd,
    output logic       wr,
    output logic [7:0] pixelw,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_W * IMG_H - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t           state, state_nxt;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] rd_cnt, wr_cnt;
    logic             v0, s1_v, s2_v, s3_v;
    logic [9:0]       s1_a, s1_b, s1_c, s1_d;
    logic [7:0]       s1_ctr;
    logic [11:0]      s2_val;

    function automatic logic [9:0] ext3(input logic [7:0] a, input logic [7:0] b2,
                                        input logic [7:0] c);
        return {2'b00, a} + {1'b0, b2, 1'b0} + {2'b00, c};
    endfunction

    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = READ;
            READ:  if (rd_cnt == LAST_IDX) state_nxt = DRAIN;
            DRAIN: if (s3_v && (wr_cnt == LAST_IDX)) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd         = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            READ:  begin rd = 1'b1; busy = 1'b1; end
            DRAIN: busy = 1'b1;
            DONE:  frame_done = 1'b1;
            default: ;
        endcase
    end

    assign wr = s3_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 2'd0;
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            mode_q <= mode;
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (state == READ) rd_cnt <= rd_cnt + 1'b1;
            if (s3_v)          wr_cnt <= wr_cnt + 1'b1;
        end
    end

    // Valid chain: memory latency (v0) followed by three engine stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0   <= 1'b0;
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s3_v <= 1'b0;
        end else begin
            v0   <= rd;
            s1_v <= v0;
            s2_v <= s1_v;
            s3_v <= s2_v;
        end
    end

    // S1: Gaussian uses a=corners, b=edges; Sobel uses a-b = Gx, c-d = Gy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a   <= '0;
            s1_b   <= '0;
            s1_c   <= '0;
            s1_d   <= '0;
            s1_ctr <= '0;
        end else if (v0) begin
            s1_ctr <= pixelr5;
            case (mode_q)
                2'd0: begin
                    s1_a <= {2'b00, pixelr1} + {2'b00, pixelr3} + {2'b00, pixelr7} + {2'b00, pixelr9};
                    s1_b <= {2'b00, pixelr2} + {2'b00, pixelr4} + {2'b00, pixelr6} + {2'b00, pixelr8};
                    s1_c <= '0;
                    s1_d <= '0;
                end
                2'd1: begin
                    s1_a <= ext3(pixelr3, pixelr6, pixelr9);
                    s1_b <= ext3(pixelr1, pixelr4, pixelr7);
                    s1_c <= ext3(pixelr7, pixelr8, pixelr9);
                    s1_d <= ext3(pixelr1, pixelr2, pixelr3);
                end
                default: begin
                    s1_a <= '0;
                    s1_b <= '0;
                    s1_c <= '0;
                    s1_d <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_val <= '0;
        end else if (s1_v) begin
            case (mode_q)
                2'd0: s2_val <= {2'b00, s1_a} + {1'b0, s1_b, 1'b0} + {2'b00, s1_ctr, 2'b00};
                2'd1: s2_val <= {2'b00, abs_diff(s1_a, s1_b)} + {2'b00, abs_diff(s1_c, s1_d)};
                default: s2_val <= {4'b0000, s1_ctr};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixelw <= 8'd0;
        end else if (s2_v) begin
            case (mode_q)
                2'd0: pixelw <= s2_val[11:4];
                2'd1: pixelw <= (s2_val > 12'd255) ? 8'hFF : s2_val[7:0];
                default: pixelw <= s2_val[7:0];
            endcase
        end
    end

endmodule

// File: tb/tb_conv3x3_engine.sv
// Randomized bench for conv3x3_engine: models the memory read latency and
// compares every written pixel and the frame framing against a reference.
module tb_conv3x3_engine;

    localparam int N = 256 * 32;

    typedef int win_t[9];

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] mode;
    logic [7:0] pix[9];
    logic       rd, wr, busy, frame_done;
    logic [7:0] pixelw;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int rd_seen, wr_seen, fd_seen, first_rd, last_rd, first_wr, last_wr, fd_cyc;
    int tb_mode;
    int last_pix = 0;
    bit rd_prev = 1'b0;
    int exp_q[$];

    conv3x3_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .pixelr1(pix[0]), .pixelr2(pix[1]), .pixelr3(pix[2]),
        .pixelr4(pix[3]), .pixelr5(pix[4]), .pixelr6(pix[5]),
        .pixelr7(pix[6]), .pixelr8(pix[7]), .pixelr9(pix[8]),
        .rd(rd), .wr(wr), .pixelw(pixelw), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int ref_pix(input int m, input win_t w);
        int gx, gy, s;
        if (m == 0) begin
            s = w[0] + w[2] + w[6] + w[8] + 2 * (w[1] + w[3] + w[5] + w[7]) + 4 * w[4];
            return s / 16;
        end else if (m == 1) begin
            gx = (w[2] + 2 * w[5] + w[8]) - (w[0] + 2 * w[3] + w[6]);
            gy = (w[6] + 2 * w[7] + w[8]) - (w[0] + 2 * w[1] + w[2]);
            s  = iabs(gx) + iabs(gy);
            return (s > 255) ? 255 : s;
        end
        return w[4];
    endfunction

    task automatic gen_window(output win_t w);
        int kind;
        kind = int'($urandom_range(0, 5));
        for (int i = 0; i < 9; i++) w[i] = 0;
        case (kind)
            0: for (int i = 0; i < 9; i++) w[i] = int'($urandom_range(0, 255));
            1: for (int i = 0; i < 9; i++) w[i] = 100;
            2: for (int i = 0; i < 9; i++) w[i] = 255;
            3: begin w[2] = 200; w[5] = 200; w[8] = 200; end
            4: w[2] = 10;
            default: begin
                for (int i = 0; i < 9; i++) w[i] = int'($urandom_range(0, 255));
                w[4] = 'h5A;
            end
        endcase
    endtask

    // One cycle: act as the registered memory, then observe the DUT outputs.
    task automatic step();
        win_t w;
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            rd_prev = 1'b0;
            last_pix = 0;
            for (int i = 0; i < 9; i++) pix[i] = 8'd0;
            return;
        end
        if (rd_prev) begin
            gen_window(w);
            for (int i = 0; i < 9; i++) pix[i] = 8'(w[i]);
            exp_q.push_back(ref_pix(tb_mode, w));
        end else begin
            for (int i = 0; i < 9; i++) pix[i] = 8'd0;
        end
        rd_prev = rd;
        if (rd) begin
            if (rd_seen == 0) first_rd = cyc;
            last_rd = cyc;
            rd_seen++;
        end
        if (wr) begin
            if (wr_seen == 0) first_wr = cyc;
            last_wr = cyc;
            wr_seen++;
            if (exp_q.size() == 0) check_val("wr_unexpected", 1, 0);
            else                   check_val("pixelw", int'(pixelw), exp_q.pop_front());
            last_pix = int'(pixelw);
        end else begin
            check_val("pixelw_hold", int'(pixelw), last_pix);
        end
        if (frame_done) begin
            fd_seen++;
            fd_cyc = cyc;
            check_val("busy_at_done", int'(busy), 0);
        end
    endtask

    task automatic clear_stats(input int m);
        rd_seen = 0; wr_seen = 0; fd_seen = 0;
        first_rd = -1; last_rd = -1; first_wr = -1; last_wr = -1; fd_cyc = -1;
        exp_q.delete();
        tb_mode = m;
    endtask

    task automatic run_frame(input int m, input bit disturb);
        clear_stats(m);
        start = 1'b1;
        mode  = 2'(m);
        step();
        start = 1'b0;
        check_val("busy_after_start", int'(busy), 1);
        for (int i = 0; i < N + 50 && fd_seen == 0; i++) begin
            if (disturb && i == 1000) begin
                start = 1'b1;
                mode  = 2'(m + 1);
            end
            if (disturb && i == 1001) start = 1'b0;
            step();
        end
        if (fd_seen == 0) check_val("frame_timeout", 0, 1);
        step();
        check_val("busy_after_done", int'(busy), 0);
        check_val("frame_done_pulse", int'(frame_done), 0);
        check_val("rd_count", rd_seen, N);
        check_val("wr_count", wr_seen, N);
        check_val("rd_contiguous", last_rd - first_rd + 1, N);
        check_val("wr_contiguous", last_wr - first_wr + 1, N);
        check_val("rd_to_wr_latency", first_wr - first_rd, 4);
        check_val("done_after_last_wr", fd_cyc - last_wr, 1);
        check_val("frame_done_count", fd_seen, 1);
        check_val("results_pending", exp_q.size(), 0);
        mode = 2'(m);
    endtask

    initial begin
        int fd_before, rd_before;
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 2'd0;
        for (int i = 0; i < 9; i++) pix[i] = 8'd0;
        clear_stats(0);
        repeat (3) step();
        check_val("reset_rd", int'(rd), 0);
        check_val("reset_wr", int'(wr), 0);
        check_val("reset_busy", int'(busy), 0);
        check_val("reset_frame_done", int'(frame_done), 0);
        check_val("reset_pixelw", int'(pixelw), 0);
        rst_n = 1'b1;
        repeat (2) step();

        run_frame(0, 1'b0);
        run_frame(1, 1'b1);
        run_frame(2, 1'b0);
        run_frame(3, 1'b1);

        // Abort a frame mid-READ with a one-cycle reset.
        clear_stats(0);
        start = 1'b1;
        mode  = 2'd0;
        step();
        start = 1'b0;
        repeat (200) step();
        check_val("abort_rd_before", int'(rd), 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("abort_rd", int'(rd), 0);
        check_val("abort_wr", int'(wr), 0);
        check_val("abort_busy", int'(busy), 0);
        check_val("abort_frame_done", int'(frame_done), 0);
        step();
        rst_n = 1'b1;
        fd_before = fd_seen;
        rd_before = rd_seen;
        repeat (20) step();
        check_val("abort_no_done", fd_seen, fd_before);
        check_val("abort_no_rd", rd_seen, rd_before);
        check_val("abort_idle_wr", int'(wr), 0);

        run_frame(0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
